response_misr_checker: RTL and testbench
========================================

RESPONSE_MISR_CHECKER -- requirements
Module: response_misr_checker

Interface
REQ-001 The block SHALL have parameter N_OUT, default 5, width of the device-under-test response word (t,n,r,k,m).
REQ-002 The block SHALL have parameter VEC_COUNT, default 512, number of response words per test run (2..1024).
REQ-003 The block SHALL have parameter SEED, default 16'hFFFF, signature register load value at run start.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port start  input  1  begin a run; sampled in IDLE and DONE only.
REQ-007 The block SHALL have port resp_valid  input  1  resp carries one response word this cycle.
REQ-008 The block SHALL have port resp  input  N_OUT  response word from the device under test.
REQ-009 The block SHALL have port golden_sig  input  16  expected final signature; stable from start to done.
REQ-010 The block SHALL have port busy  output  1  high in RUN.
REQ-011 The block SHALL have port done  output  1  high in DONE.
REQ-012 The block SHALL have port pass  output  1  final signature equals golden_sig; valid while done.
REQ-013 The block SHALL have port signature  output  16  current signature register.
REQ-014 The block SHALL have port vec_count  output  11  response words absorbed in the current run.

Function
REQ-015 The state machine SHALL have states IDLE, RUN and DONE, one-hot or binary.
REQ-016 IDLE with start=1 SHALL go to RUN next edge, loading signature<=SEED and vec_count<=0.
REQ-017 RUN with resp_valid=1 SHALL compute signature <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ zero-extended resp, and increment vec_count.
REQ-018 RUN with resp_valid=0 SHALL hold signature and vec_count.
REQ-019 The accepted word that brings vec_count to VEC_COUNT SHALL also move the state to DONE on the same edge, with latency 1 clock from the last resp_valid to done=1.
REQ-020 pass SHALL be registered on that same edge as (updated signature == golden_sig) and held through DONE.
REQ-021 start in RUN SHALL be ignored; resp_valid in IDLE or DONE SHALL be ignored with no signature or count change.
REQ-022 DONE with start=1 SHALL restart exactly as REQ-016 (done, pass cleared on that edge).
REQ-023 start and resp_valid asserted together in IDLE/DONE SHALL load SEED only; that resp word is not absorbed.
REQ-024 vec_count SHALL never exceed VEC_COUNT; no wrap within a run.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, signature=SEED, vec_count=0, busy=0, done=0, pass=0, regardless of clock.
REQ-026 rst asserted mid-RUN SHALL abort the run; the next start SHALL begin a fresh run with no residual state.
REQ-027 Deassertion of rst SHALL take effect at the next rising clk edge only.

Verification
REQ-028 VEC_COUNT=2, start, then resp=0 twice -> signature EFDF after the first word, CF9F after the second; done=1 one clock after the second word; golden_sig=16'hCF9F gives pass=1.
REQ-029 Same stimulus with golden_sig=16'hCF9E -> done=1, pass=0, signature=CF9F.
REQ-030 VEC_COUNT=2, first resp=5'h1F -> signature EFC0; resp_valid gaps between words -> signature and count unchanged across gaps.
REQ-031 Default VEC_COUNT=512 with an exhaustive 9-input stimulus, one word per 5 clocks -> busy for 512 words, vec_count=512, done=1; start held during RUN has no effect.
REQ-032 rst pulsed after 100 words -> outputs at reset values asynchronously; a new run then matches an uninterrupted run's signature.
REQ-033 start together with resp_valid in DONE -> restart with signature=FFFF, vec_count=0, done=0, pass=0.

Source files
------------

// File: rtl/response_misr_checker.sv
`default_nettype none
// ============================================================================
// Module   : response_misr_checker
// Purpose  : Compacts a run of VEC_COUNT response words from a device under
//            test into a 16-bit multiple-input signature (CRC-CCITT feedback,
//            polynomial 0x1021). When the final word has been absorbed, the
//            signature is compared with golden_sig, and the pass/fail verdict
//            is held until the next run starts.
// Ports    : clk        - single clock, all state on the rising edge
//            rst        - asynchronous active-high reset
//            start      - begin a run (sampled only in IDLE and DONE)
//            resp_valid - resp carries one response word this cycle
//            resp       - N_OUT-bit response word
//            golden_sig - expected final signature
//            busy       - high while a run is in progress
//            done       - high once the run has completed
//            pass       - final signature matched golden_sig (valid with done)
//            signature  - current signature register
//            vec_count  - words absorbed in the current run
// Revision : 1.0 - initial release
// ============================================================================
module response_misr_checker #(
  parameter int          N_OUT     = 5,
  parameter int          VEC_COUNT = 512,
  parameter logic [15:0] SEED      = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [N_OUT-1:0] resp,
  input  logic [15:0]      golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [10:0]      vec_count
);

  localparam logic [15:0] POLY     = 16'h1021;
  localparam logic [10:0] CNT_LAST = 11'(VEC_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sig_q, sig_d;
  logic [10:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [15:0] resp_ext;
  logic [15:0] sig_next;
  logic [10:0] cnt_inc;

  always_comb begin
    resp_ext = 16'(resp);
    // Shift with polynomial feedback, then fold the new word into the low bits.
    sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ resp_ext;
    cnt_inc  = cnt_q + 11'd1;

    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A word presented together with start is not absorbed: the run
        // begins from SEED on this edge.
        if (start) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          cnt_d   = 11'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (resp_valid) begin
          sig_d = sig_next;
          cnt_d = cnt_inc;
          // The last word completes the run on the same edge, so the verdict
          // is taken from the freshly updated signature, not sig_q.
          if (cnt_inc == CNT_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (sig_next == golden_sig);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sig_d   = SEED;
        cnt_d   = 11'd0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= 11'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_response_misr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_misr_checker
// Purpose  : Self-checking bench for response_misr_checker. Two instances are
//            used: one with VEC_COUNT=2 for short directed and random runs,
//            and one with the default VEC_COUNT=512 for full-length runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_misr_checker;

  localparam logic [15:0] SEED = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;

  // small instance (VEC_COUNT = 2)
  logic        s_start, s_valid;
  logic [4:0]  s_resp;
  logic [15:0] s_golden;
  logic        s_busy, s_done, s_pass;
  logic [15:0] s_sig;
  logic [10:0] s_cnt;

  // big instance (VEC_COUNT = 512)
  logic        b_start, b_valid;
  logic [4:0]  b_resp;
  logic [15:0] b_golden;
  logic        b_busy, b_done, b_pass;
  logic [15:0] b_sig;
  logic [10:0] b_cnt;

  response_misr_checker #(.N_OUT(5), .VEC_COUNT(2), .SEED(16'hFFFF)) u_dut_small (
    .clk(clk), .rst(rst), .start(s_start), .resp_valid(s_valid), .resp(s_resp),
    .golden_sig(s_golden), .busy(s_busy), .done(s_done), .pass(s_pass),
    .signature(s_sig), .vec_count(s_cnt)
  );

  response_misr_checker u_dut_big (
    .clk(clk), .rst(rst), .start(b_start), .resp_valid(b_valid), .resp(b_resp),
    .golden_sig(b_golden), .busy(b_busy), .done(b_done), .pass(b_pass),
    .signature(b_sig), .vec_count(b_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          d;
    logic [15:0] sig;
    logic        pass;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: one run per instance, tracked as plain counters/flags.
  int          vecs[2] = '{2, 512};
  logic [15:0] m_sig[2];
  int          m_cnt[2];
  bit          m_run[2];
  bit          m_done[2];
  bit          m_pass[2];

  logic [4:0]  words[512];
  logic [15:0] ref_sig;

  // Signature update as polynomial arithmetic over GF(2): multiply by x,
  // reduce modulo x^16+x^12+x^5+1, then add the response word.
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] w);
    int unsigned x;
    x = {15'd0, s, 1'b0};
    if (x >= 32'h0001_0000) x = x ^ 32'h0001_1021;
    return x[15:0] ^ {11'd0, w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_state(input int d);
    if (d == 0) begin
      check("s_signature", s_sig, m_sig[0]);
      check("s_vec_count", s_cnt, m_cnt[0]);
      check("s_busy", s_busy, m_run[0]);
      check("s_done", s_done, m_done[0]);
      check("s_pass", s_pass, m_pass[0]);
    end else begin
      check("b_signature", b_sig, m_sig[1]);
      check("b_vec_count", b_cnt, m_cnt[1]);
      check("b_busy", b_busy, m_run[1]);
      check("b_done", b_done, m_done[1]);
      check("b_pass", b_pass, m_pass[1]);
    end
  endtask

  // Drive one clock of stimulus to instance d, advance the model, check after the edge.
  task automatic cycle(input int d, input logic st, input logic v, input logic [4:0] w);
    exp_t e;
    if (d == 0) begin s_start = st; s_valid = v; s_resp = w; end
    else        begin b_start = st; b_valid = v; b_resp = w; end
    if (!m_run[d]) begin
      if (st) begin
        m_run[d] = 1; m_sig[d] = SEED; m_cnt[d] = 0; m_done[d] = 0; m_pass[d] = 0;
      end
    end else if (v) begin
      m_sig[d] = misr(m_sig[d], w);
      m_cnt[d]++;
      if (m_cnt[d] == vecs[d]) begin
        m_run[d]  = 0;
        m_done[d] = 1;
        m_pass[d] = (m_sig[d] == ((d == 0) ? s_golden : b_golden));
        e.d = d; e.sig = m_sig[d]; e.pass = m_pass[d];
        sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (d == 0) begin s_start = 0; s_valid = 0; end
    else        begin b_start = 0; b_valid = 0; end
    check_state(d);
  endtask

  // Assert reset away from any clock edge and check outputs before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_s_sig", s_sig, SEED);
    check("rst_s_cnt", s_cnt, 0);
    check("rst_s_flags", {s_busy, s_done, s_pass}, 0);
    check("rst_b_sig", b_sig, SEED);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_b_flags", {b_busy, b_done, b_pass}, 0);
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_sig[d] = SEED; m_cnt[d] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every rising done pops one expected completion.
  logic [1:0] done_prev = 2'b00;
  always @(negedge clk) begin
    logic [1:0] now;
    exp_t       e;
    now = {b_done, s_done};
    for (int d = 0; d < 2; d++) begin
      if (now[d] && !done_prev[d]) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", d, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_instance", d, e.d);
          check("sb_signature", (d == 0) ? s_sig : b_sig, e.sig);
          check("sb_pass", (d == 0) ? s_pass : b_pass, e.pass);
        end
      end
    end
    done_prev <= now;
  end

  initial begin
    logic [4:0]  w0, w1;
    logic [15:0] es;

    s_start = 0; s_valid = 0; s_resp = 0; s_golden = 0;
    b_start = 0; b_valid = 0; b_resp = 0; b_golden = 0;
    do_reset();

    // Known-answer run, matching golden
    s_golden = 16'hCF9F;
    cycle(0, 1, 0, 5'h00); check("ka_start_sig", s_sig, 16'hFFFF);
    cycle(0, 0, 1, 5'h00); check("ka_word1", s_sig, 16'hEFDF);
    cycle(0, 0, 1, 5'h00); check("ka_word2", s_sig, 16'hCF9F);
    check("ka_done", s_done, 1); check("ka_pass", s_pass, 1);
    cycle(0, 0, 1, 5'h03); check("done_ignores_word", s_sig, 16'hCF9F);

    // Known-answer run, mismatching golden, with a gap
    s_golden = 16'hCF9E;
    cycle(0, 1, 0, 5'h00);
    cycle(0, 0, 1, 5'h00);
    cycle(0, 0, 0, 5'h07);
    cycle(0, 0, 1, 5'h00);
    check("ka_fail_done", s_done, 1); check("ka_fail_pass", s_pass, 0);
    check("ka_fail_sig", s_sig, 16'hCF9F);

    // Word 0x1F first, gaps, start during RUN ignored
    w1 = 5'($urandom);
    s_golden = misr(misr(SEED, 5'h1F), w1);
    cycle(0, 1, 0, 5'h00);
    cycle(0, 0, 1, 5'h1F); check("w1f_sig", s_sig, 16'hEFC0);
    repeat (3) cycle(0, 0, 0, 5'($urandom));
    check("gap_sig", s_sig, 16'hEFC0); check("gap_cnt", s_cnt, 1);
    cycle(0, 1, 1, w1);
    check("w1f_pass", s_pass, 1);

    // start with resp_valid in DONE: restart, word not absorbed
    cycle(0, 1, 1, 5'h1F);
    check("restart_sig", s_sig, 16'hFFFF); check("restart_cnt", s_cnt, 0);
    check("restart_done", s_done, 0); check("restart_pass", s_pass, 0);
    cycle(0, 0, 1, 5'($urandom));
    cycle(0, 0, 1, 5'($urandom));

    // Random short runs
    for (int r = 0; r < 12; r++) begin
      w0 = 5'($urandom); w1 = 5'($urandom);
      es = misr(misr(SEED, w0), w1);
      s_golden = (r % 2 == 0) ? es : (es ^ (16'h1 << $urandom_range(15, 0)));
      cycle(0, 1, 1'($urandom), 5'($urandom));
      repeat ($urandom_range(2, 0)) cycle(0, 1'($urandom), 0, 5'($urandom));
      cycle(0, 1'($urandom), 1, w0);
      repeat ($urandom_range(2, 0)) cycle(0, 1'($urandom), 0, 5'($urandom));
      cycle(0, 0, 1, w1);
      check("rand_pass", s_pass, (r % 2 == 0) ? 1 : 0);
    end

    // Full-length run: one word every 5 clocks, start held throughout RUN
    ref_sig = SEED;
    for (int i = 0; i < 512; i++) begin
      words[i] = 5'($urandom);
      ref_sig  = misr(ref_sig, words[i]);
    end
    b_golden = ref_sig;
    cycle(1, 1, 0, 5'h00);
    for (int i = 0; i < 512; i++) begin
      cycle(1, 1, 1, words[i]);
      if (i < 511) repeat (4) cycle(1, 1, 0, 5'($urandom));
    end
    check("full_cnt", b_cnt, 512); check("full_done", b_done, 1);
    check("full_pass", b_pass, 1); check("full_sig", b_sig, ref_sig);

    // Abort after 100 words, then an uninterrupted rerun
    cycle(1, 1, 0, 5'h00);
    for (int i = 0; i < 100; i++) cycle(1, 0, 1, words[i]);
    check("abort_cnt_before", b_cnt, 100);
    do_reset();
    cycle(1, 1, 0, 5'h00);
    for (int i = 0; i < 512; i++) cycle(1, 0, 1, words[i]);
    check("rerun_sig", b_sig, ref_sig); check("rerun_done", b_done, 1);
    check("rerun_pass", b_pass, 1);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
